// File: rtl/pulse_monitor_if.sv
// Pulse monitor signal bundle: the monitored pulse line and the measurement results.
// The monitor sits on the slave side; whoever drives the pulse and consumes results is the master.
interface pulse_monitor_if #(
  parameter int CNT_W = 30
);
  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             lost;
  logic [15:0]      edge_count;

  modport master (
    output pulse_in,
    input  period,
    input  period_valid,
    input  lost,
    input  edge_count
  );

  modport slave (
    input  pulse_in,
    output period,
    output period_valid,
    output lost,
    output edge_count
  );
endinterface

// File: rtl/pulse_monitor.sv
// Measures the rising-edge period of an asynchronous square wave in clk cycles and flags pulse loss.
// Define PULSE_MONITOR_AVG_EN to report a running mean of the last 4 periods instead of the last one.
//
// state      | meaning
// WAIT_FIRST | no reference edge yet, counter parked at 0
// MEASURE    | counting cycles since the last accepted rising edge
// LOST       | no edge within TIMEOUT, waiting for a new reference edge
module pulse_monitor #(
  parameter int CNT_W       = 30,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  pulse_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LOST       = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             lost_q;
  logic [15:0]      edge_cnt;

  // rise is registered so the FSM sees it one edge after the synchroniser output changes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], bus.pulse_in};
      sync_prev <= sync[SYNC_STAGES-1];
      rise      <= sync[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  always_comb begin
    meas = cnt + CNT_W'(1);
  end

`ifdef PULSE_MONITOR_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] sum_next;
  logic [2:0]       fill;

  // oldest entry is zero until the window is full, so the subtraction is always safe
  always_comb begin
    sum_next = sum + (CNT_W+2)'(meas) - (CNT_W+2)'(hist[3]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_FIRST;
      cnt      <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      edge_cnt <= '0;
`ifdef PULSE_MONITOR_AVG_EN
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum  <= '0;
      fill <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (rise) edge_cnt <= edge_cnt + 16'd1;

      case (state)
        WAIT_FIRST: begin
          cnt <= '0;
          if (rise) state <= MEASURE;
        end

        MEASURE: begin
          if (rise) begin
            cnt <= '0;
`ifdef PULSE_MONITOR_AVG_EN
            hist[0] <= meas;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            sum <= sum_next;
            if (fill != 3'd4) fill <= fill + 3'd1;
            if (fill >= 3'd3) begin
              period_q <= sum_next[CNT_W+1:2];
              valid_q  <= 1'b1;
            end
`else
            period_q <= meas;
            valid_q  <= 1'b1;
`endif
          end else if (cnt == CNT_TC) begin
            state  <= LOST;
            lost_q <= 1'b1;
            cnt    <= '0;
`ifdef PULSE_MONITOR_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum  <= '0;
            fill <= '0;
`endif
          end else begin
            cnt <= meas;
          end
        end

        LOST: begin
          cnt <= '0;
          if (rise) begin
            state  <= MEASURE;
            lost_q <= 1'b0;
          end
        end

        default: begin
          state <= WAIT_FIRST;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.lost         = lost_q;
  assign bus.edge_count   = edge_cnt;

endmodule

// File: tb/tb_pulse_monitor.sv
// Self-checking bench for pulse_monitor: directed and random pulse trains against a timestamp model.
// Works with or without PULSE_MONITOR_AVG_EN defined.
module tb_pulse_monitor;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 50;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_monitor_if #(.CNT_W(CNT_W)) bus ();

  pulse_monitor #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sampled-input history plus timestamps of accepted edges
  int         cyc = 0;
  logic [4:0] samp = '0;
  bit         have_ref = 0;
  bit         m_lost = 0;
  int         last_t = 0;
  int         m_period = 0;
  bit         m_valid = 0;
  int         m_edges = 0;
  int         win[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic record(input int per);
`ifdef PULSE_MONITOR_AVG_EN
    int s = 0;
    win.push_back(per);
    if (win.size() > 4) void'(win.pop_front());
    if (win.size() == 4) begin
      foreach (win[i]) s += win[i];
      m_period = s / 4;
      m_valid  = 1;
    end
`else
    m_period = per;
    m_valid  = 1;
`endif
  endtask

  // A sampled 0->1 at edge N is acted on at edge N+3
  task automatic model_step(input logic p, input logic r);
    bit rise;
    m_valid = 0;
    if (r) begin
      samp = '0; have_ref = 0; m_lost = 0; m_period = 0; m_edges = 0;
      win.delete();
    end else begin
      samp = {samp[3:0], p};
      rise = samp[3] & ~samp[4];
      if (rise) begin
        m_edges = (m_edges + 1) % 65536;
        if (!have_ref || m_lost) begin
          have_ref = 1; m_lost = 0; last_t = cyc;
        end else begin
          record(cyc - last_t);
          last_t = cyc;
        end
      end else if (have_ref && !m_lost && (cyc - last_t) == TIMEOUT) begin
        m_lost = 1;
        win.delete();
      end
    end
  endtask

  task automatic tick(input logic p, input logic r);
    bus.pulse_in = p;
    reset = r;
    @(posedge clk);
    #1;
    cyc++;
    model_step(p, r);
    chk("period", int'(bus.period), m_period);
    chk("period_valid", int'(bus.period_valid), int'(m_valid));
    chk("lost", int'(bus.lost), int'(m_lost));
    chk("edge_count", int'(bus.edge_count), m_edges);
  endtask

  task automatic sq(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) tick(1'b1, 1'b0);
      repeat (lo) tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("reset_period", int'(bus.period), 0);
    chk("reset_lost", int'(bus.lost), 0);
    chk("reset_edges", int'(bus.edge_count), 0);

    // 10 high / 10 low
    sq(10, 10, 6);
    chk("steady_period", int'(bus.period), 20);
    chk("steady_edges", int'(bus.edge_count), 6);

    // hold low -> loss, period retained
    repeat (70) tick(1'b0, 1'b0);
    chk("loss_lost", int'(bus.lost), 1);
    chk("loss_period", int'(bus.period), 20);

    // resume, then period exactly TIMEOUT
    sq(10, 10, 4);
    chk("resume_lost", int'(bus.lost), 0);
    sq(25, 25, 3);
    chk("tc_lost", int'(bus.lost), 0);
`ifdef PULSE_MONITOR_AVG_EN
    chk("tc_period", int'(bus.period), 35);
`else
    chk("tc_period", int'(bus.period), 50);
`endif

    // reset mid-period
    repeat (7) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("midrst_period", int'(bus.period), 0);
    chk("midrst_valid", int'(bus.period_valid), 0);
    chk("midrst_edges", int'(bus.edge_count), 0);
    sq(8, 9, 6);
    chk("midrst_after", int'(bus.period), 17);

    // periods 20,20,24,25 after a fresh reset
    repeat (2) tick(1'b0, 1'b1);
    sq(10, 10, 2);
    sq(12, 12, 1);
    sq(12, 13, 1);
    sq(10, 10, 1);
`ifdef PULSE_MONITOR_AVG_EN
    chk("avg_period", int'(bus.period), 22);
`else
    chk("last_period", int'(bus.period), 25);
`endif

    // random square waves with occasional dropouts
    repeat (300) begin
      int len;
      int hi;
      len = $urandom_range(60, 2);
      hi  = $urandom_range(len - 1, 1);
      sq(hi, len - hi, 1);
      if ($urandom_range(15, 0) == 0) repeat ($urandom_range(80, 30)) tick(1'b0, 1'b0);
    end

    // raw noise with rare resets
    repeat (600) tick(1'($urandom_range(1, 0)), ($urandom_range(199, 0) == 0));

    // fastest legal pulse
    sq(1, 1, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
